// File: rtl/fact_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : fact_requester_if
// Description : Request, factorial-unit and response signal bundle for the
//               fact_requester. The master modport is the requester's view;
//               the slave modport is the view of the surrounding environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fact_requester_if;
  // request port
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_n;
  // factorial unit Go/Done/Err handshake
  logic        fu_go;
  logic [3:0]  fu_n;
  logic        fu_done;
  logic        fu_err;
  logic [31:0] fu_nf;
  // response port
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_nf;
  logic        rsp_err;
  logic        rsp_tmo;
  // status
  logic        busy;

  modport master (
    input  req_valid, req_n, fu_done, fu_err, fu_nf, rsp_ready,
    output req_ready, fu_go, fu_n, rsp_valid, rsp_nf, rsp_err, rsp_tmo, busy
  );

  modport slave (
    output req_valid, req_n, fu_done, fu_err, fu_nf, rsp_ready,
    input  req_ready, fu_go, fu_n, rsp_valid, rsp_nf, rsp_err, rsp_tmo, busy
  );
endinterface
`default_nettype wire

// File: rtl/fact_requester.sv
`default_nettype none
// ============================================================================
// Module      : fact_requester
// Description : Initiator for the factorial unit. Takes one n at a time,
//               pulses fu_go, waits for Done/Err or a timeout and returns the
//               result on a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_requester #(
  parameter int TIMEOUT = 255,  // WAIT cycles before abort, 1 .. 2**TW-1
  parameter int TW      = 8     // timeout counter width
) (
  input  wire logic       clk,
  input  wire logic       rst,  // asynchronous, active-low
  fact_requester_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Count value on which the last permitted WAIT cycle is evaluated.
  localparam logic [TW-1:0] C_LAST = TW'(TIMEOUT - 1);

  state_t        state_q,     state_d;
  logic          fu_go_q,     fu_go_d;
  logic [3:0]    fu_n_q,      fu_n_d;
  logic [TW-1:0] count_q,     count_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_nf_q,    rsp_nf_d;
  logic          rsp_err_q,   rsp_err_d;
  logic          rsp_tmo_q,   rsp_tmo_d;

  // Next-state and registered-output computation; every field holds unless
  // the current state changes it. fu_go is set only on the IDLE->LAUNCH
  // transition so it is high for exactly the LAUNCH cycle.
  always_comb begin
    state_d     = state_q;
    fu_go_d     = 1'b0;
    fu_n_d      = fu_n_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q;
    rsp_nf_d    = rsp_nf_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          fu_n_d  = bus.req_n;
          fu_go_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        count_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Err outranks Done, so a simultaneous Done+Err reports an error.
        if (bus.fu_err) begin
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b0;
          rsp_nf_d    = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (bus.fu_done) begin
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
          rsp_nf_d    = bus.fu_nf;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (count_q == C_LAST) begin
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b1;
          rsp_nf_d    = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          count_d = count_q + TW'(1);
        end
      end
      S_RESP: begin
        // rsp_nf is deliberately left alone; it holds until the next capture.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fu_go_q     <= 1'b0;
      fu_n_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_nf_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fu_go_q     <= fu_go_d;
      fu_n_q      <= fu_n_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nf_q    <= rsp_nf_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.fu_go     = fu_go_q;
  assign bus.fu_n      = fu_n_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_nf    = rsp_nf_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tmo   = rsp_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_fact_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_fact_requester
// Description : Directed self-checking bench for fact_requester with
//               TIMEOUT=16; the bench plays both the request source and the
//               factorial unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fact_requester;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  int   go_cnt;

  fact_requester_if ifc ();

  fact_requester #(
    .TIMEOUT(16),
    .TW     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which fu_go is seen high at a rising edge.
  initial go_cnt = 0;
  always @(posedge clk) if (ifc.fu_go === 1'b1) go_cnt++;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present n, check the LAUNCH cycle, then step into the first WAIT cycle.
  task automatic send_req(input logic [3:0] n);
    int start_go;
    int waited;
    waited = 0;
    while (ifc.req_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check("req_ready_before_req", {31'd0, ifc.req_ready}, 32'd1);
    start_go      = go_cnt;
    ifc.req_valid = 1'b1;
    ifc.req_n     = n;
    tick();
    ifc.req_valid = 1'b0;
    check("launch_fu_go", {31'd0, ifc.fu_go}, 32'd1);
    check("launch_fu_n",  {28'd0, ifc.fu_n}, {28'd0, n});
    check("launch_busy",  {31'd0, ifc.busy}, 32'd1);
    tick();
    check("wait_fu_go",   {31'd0, ifc.fu_go}, 32'd0);
    check("go_pulses",    32'(go_cnt - start_go), 32'd1);
  endtask

  // Factorial unit answers after 'delay' WAIT cycles with a one-cycle pulse.
  task automatic unit_reply(input logic done, input logic err, input logic [31:0] nf,
                            input int delay);
    repeat (delay) begin
      check("no_early_rsp", {31'd0, ifc.rsp_valid}, 32'd0);
      tick();
    end
    ifc.fu_done = done;
    ifc.fu_err  = err;
    ifc.fu_nf   = nf;
    tick();
    ifc.fu_done = 1'b0;
    ifc.fu_err  = 1'b0;
    check("rsp_valid_rise", {31'd0, ifc.rsp_valid}, 32'd1);
  endtask

  // Check the held response, accept it, and check the return to IDLE.
  task automatic take_rsp(input logic [31:0] nf, input logic err, input logic tmo);
    check("rsp_valid", {31'd0, ifc.rsp_valid}, 32'd1);
    check("rsp_nf",    ifc.rsp_nf, nf);
    check("rsp_err",   {31'd0, ifc.rsp_err}, {31'd0, err});
    check("rsp_tmo",   {31'd0, ifc.rsp_tmo}, {31'd0, tmo});
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, ifc.rsp_valid}, 32'd0);
    check("idle_req_ready", {31'd0, ifc.req_ready}, 32'd1);
    check("idle_err_clr",   {30'd0, ifc.rsp_err, ifc.rsp_tmo}, 32'd0);
    check("rsp_nf_kept",    ifc.rsp_nf, nf);
  endtask

  initial begin
    logic spurious;
    int   go_snap;
    n_vec  = 0;
    n_miss = 0;
    rst           = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_n     = 4'd0;
    ifc.fu_done   = 1'b0;
    ifc.fu_err    = 1'b0;
    ifc.fu_nf     = 32'd0;
    ifc.rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_fu_go",     {31'd0, ifc.fu_go}, 32'd0);
    check("rst_fu_n",      {28'd0, ifc.fu_n}, 32'd0);
    check("rst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    check("rst_rsp_nf",    ifc.rsp_nf, 32'd0);
    check("rst_flags",     {30'd0, ifc.rsp_err, ifc.rsp_tmo}, 32'd0);
    check("rst_busy",      {31'd0, ifc.busy}, 32'd0);
    check("rst_req_ready", {31'd0, ifc.req_ready}, 32'd1);
    rst = 1'b1;
    tick();

    // Stale Done while IDLE is ignored
    ifc.fu_done = 1'b1;
    ifc.fu_nf   = 32'd777;
    tick();
    ifc.fu_done = 1'b0;
    check("stale_done_idle", {31'd0, ifc.rsp_valid}, 32'd0);

    // 1: 5! = 120
    send_req(4'd5);
    unit_reply(1'b1, 1'b0, 32'd120, 3);
    take_rsp(32'd120, 1'b0, 1'b0);

    // 2: 12! then 0!, back-to-back and in order
    send_req(4'd12);
    unit_reply(1'b1, 1'b0, 32'h1C8C_FC00, 2);
    take_rsp(32'd479001600, 1'b0, 1'b0);
    send_req(4'd0);
    unit_reply(1'b1, 1'b0, 32'd1, 0);
    take_rsp(32'd1, 1'b0, 1'b0);

    // 3: Err, then Done and Err together (Err wins, nf forced to 0)
    send_req(4'd13);
    unit_reply(1'b0, 1'b1, 32'hDEAD_BEEF, 1);
    take_rsp(32'd0, 1'b1, 1'b0);
    send_req(4'd9);
    unit_reply(1'b1, 1'b1, 32'd362880, 2);
    take_rsp(32'd0, 1'b1, 1'b0);

    // 4: Timeout 16 cycles after WAIT entry, late Done ignored
    send_req(4'd7);
    repeat (15) tick();
    check("tmo_not_yet", {31'd0, ifc.rsp_valid}, 32'd0);
    tick();
    check("tmo_valid", {31'd0, ifc.rsp_valid}, 32'd1);
    check("tmo_flag",  {31'd0, ifc.rsp_tmo}, 32'd1);
    ifc.fu_done = 1'b1;
    ifc.fu_nf   = 32'd5040;
    tick();
    ifc.fu_done = 1'b0;
    take_rsp(32'd0, 1'b0, 1'b1);

    // 5: Back-pressure on the response, second request not accepted
    send_req(4'd3);
    unit_reply(1'b1, 1'b0, 32'd6, 1);
    go_snap       = go_cnt;
    ifc.req_valid = 1'b1;
    ifc.req_n     = 4'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd1);
      check("bp_rsp_nf",    ifc.rsp_nf, 32'd6);
      check("bp_req_ready", {31'd0, ifc.req_ready}, 32'd0);
      check("bp_fu_n",      {28'd0, ifc.fu_n}, 32'd3);
    end
    ifc.req_valid = 1'b0;
    check("bp_no_go", 32'(go_cnt - go_snap), 32'd0);
    take_rsp(32'd6, 1'b0, 1'b0);

    // rsp_ready with no pending response has no effect
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
    check("idle_rsp_ready", {31'd0, ifc.rsp_valid}, 32'd0);
    check("idle_rsp_ready_st", {31'd0, ifc.req_ready}, 32'd1);

    // 6: Reset pulled mid-WAIT
    send_req(4'd4);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("arst_fu_n",      {28'd0, ifc.fu_n}, 32'd0);
    check("arst_busy",      {31'd0, ifc.busy}, 32'd0);
    check("arst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    check("arst_rsp_nf",    ifc.rsp_nf, 32'd0);
    ifc.fu_done = 1'b1;
    ifc.fu_nf   = 32'd24;
    tick();
    tick();
    rst = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifc.rsp_valid !== 1'b0 || ifc.fu_go !== 1'b0) spurious = 1'b1;
    end
    ifc.fu_done = 1'b0;
    check("post_rst_quiet", {31'd0, spurious}, 32'd0);

    // Recovery after reset
    send_req(4'd6);
    unit_reply(1'b1, 1'b0, 32'd720, 4);
    take_rsp(32'd720, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
